// File: rtl/seq_alu_unit.sv
// Multi-cycle handshaked ALU: single-cycle logic/arith/shift ops, iterative
// shift-add multiply and restoring divide, one operation in flight.
module seq_alu_unit #(
  parameter int ALU_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_SIZE-1:0] alu_in_a,
  input  logic [ALU_SIZE-1:0] alu_in_b,
  input  logic [3:0]          alu_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_SIZE-1:0] alu_out,
  output logic [ALU_SIZE-1:0] alu_rem,
  output logic                carry_out,
  output logic                zero_flag,
  output logic                div_zero
);

  localparam int SHAMT_W = $clog2(ALU_SIZE);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [SHAMT_W-1:0]  r_cnt;
  logic                r_is_div;
  logic [ALU_SIZE-1:0] r_opnd;
  logic [ALU_SIZE-1:0] r_hi;
  logic [ALU_SIZE-1:0] r_lo;
  logic [ALU_SIZE-1:0] r_out;
  logic [ALU_SIZE-1:0] r_rem;
  logic                r_carry;
  logic                r_zero;
  logic                r_dz;

  logic [ALU_SIZE:0]   w_add;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [SHAMT_W-1:0]  w_rot;
  logic [ALU_SIZE-1:0] w_res;
  logic [ALU_SIZE-1:0] w_rem;
  logic                w_carry;
  logic                w_dz;
  logic                w_start_iter;
  logic [ALU_SIZE:0]   w_sum;
  logic [ALU_SIZE:0]   w_trial;
  logic [ALU_SIZE:0]   w_diff;
  logic [ALU_SIZE-1:0] w_hi_nxt;
  logic [ALU_SIZE-1:0] w_lo_nxt;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign alu_out   = r_out;
  assign alu_rem   = r_rem;
  assign carry_out = r_carry;
  assign zero_flag = r_zero;
  assign div_zero  = r_dz;

  assign w_add        = {1'b0, alu_in_a} + {1'b0, alu_in_b};
  assign w_shamt      = alu_in_b[SHAMT_W-1:0];
  assign w_start_iter = (alu_sel == OP_MUL) || ((alu_sel == OP_DIV) && (alu_in_b != '0));

  // Rotate amount folded into 0..ALU_SIZE-1; only matters for non-power-of-2 widths
  always_comb begin
    w_rot = w_shamt;
    if ({1'b0, w_shamt} >= (SHAMT_W + 1)'(ALU_SIZE))
      w_rot = w_shamt - SHAMT_W'(ALU_SIZE);
  end

  always_comb begin
    w_res   = '0;
    w_rem   = '0;
    w_carry = 1'b0;
    w_dz    = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        w_res   = w_add[ALU_SIZE-1:0];
        w_carry = w_add[ALU_SIZE];
      end
      OP_SUB: begin
        w_res   = alu_in_a - alu_in_b;
        w_carry = (alu_in_a < alu_in_b);
      end
      OP_MUL:  w_res = '0;
      OP_DIV: begin
        if (alu_in_b == '0) begin
          w_res = '1;
          w_rem = alu_in_a;
          w_dz  = 1'b1;
        end
      end
      OP_SHL:  w_res = alu_in_a << w_shamt;
      OP_SHR:  w_res = alu_in_a >> w_shamt;
      OP_ROL:  w_res = (alu_in_a << w_rot) | (alu_in_a >> (32'(ALU_SIZE) - 32'(w_rot)));
      OP_ROR:  w_res = (alu_in_a >> w_rot) | (alu_in_a << (32'(ALU_SIZE) - 32'(w_rot)));
      OP_AND:  w_res = alu_in_a & alu_in_b;
      OP_OR:   w_res = alu_in_a | alu_in_b;
      OP_XOR:  w_res = alu_in_a ^ alu_in_b;
      OP_NOR:  w_res = ~(alu_in_a | alu_in_b);
      OP_NAND: w_res = ~(alu_in_a & alu_in_b);
      OP_XNOR: w_res = ~(alu_in_a ^ alu_in_b);
      OP_GT:   w_res = {{(ALU_SIZE-1){1'b0}}, (alu_in_a > alu_in_b)};
      OP_EQ:   w_res = {{(ALU_SIZE-1){1'b0}}, (alu_in_a == alu_in_b)};
    endcase
  end

  // Shared iteration datapath: mul keeps {partial product, multiplier} in {hi, lo},
  // div keeps {partial remainder, dividend/quotient} in {hi, lo}.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_trial = {r_hi, r_lo[ALU_SIZE-1]};
  assign w_diff  = w_trial - {1'b0, r_opnd};

  always_comb begin
    if (r_is_div) begin
      if (!w_diff[ALU_SIZE]) begin
        w_hi_nxt = w_diff[ALU_SIZE-1:0];
        w_lo_nxt = {r_lo[ALU_SIZE-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_trial[ALU_SIZE-1:0];
        w_lo_nxt = {r_lo[ALU_SIZE-2:0], 1'b0};
      end
    end else begin
      {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[ALU_SIZE-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_out    <= '0;
      r_rem    <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_start_iter) begin
              r_state  <= S_BUSY;
              r_cnt    <= '0;
              r_is_div <= (alu_sel == OP_DIV);
              r_opnd   <= (alu_sel == OP_DIV) ? alu_in_b : alu_in_a;
              r_hi     <= '0;
              r_lo     <= (alu_sel == OP_DIV) ? alu_in_a : alu_in_b;
            end else begin
              r_state <= S_DONE;
              r_out   <= w_res;
              r_rem   <= w_rem;
              r_carry <= w_carry;
              r_zero  <= (w_res == '0);
              r_dz    <= w_dz;
            end
          end
        end
        S_BUSY: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(ALU_SIZE - 1)) begin
            r_state <= S_DONE;
            r_out   <= w_lo_nxt;
            r_rem   <= r_is_div ? w_hi_nxt : '0;
            r_carry <= !r_is_div && (|w_hi_nxt);
            r_zero  <= (w_lo_nxt == '0);
            r_dz    <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Bench for seq_alu_unit: directed corner cases plus random ops against an
// arithmetic reference model, with latency, backpressure and reset checks.
module tb_seq_alu_unit;

  localparam int W   = 8;
  localparam int SHW = $clog2(W);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] alu_in_a;
  logic [W-1:0] alu_in_b;
  logic [3:0]   alu_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_rem;
  logic         carry_out;
  logic         zero_flag;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  longint unsigned e_res, e_rem;
  bit              e_c, e_dz;
  int              e_lat;

  seq_alu_unit #(.ALU_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_sel(alu_sel),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .alu_rem(alu_rem), .carry_out(carry_out), .zero_flag(zero_flag),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [3:0] op, input longint unsigned a,
                                input longint unsigned b, output longint unsigned res,
                                output longint unsigned rem, output bit c,
                                output bit dz, output int lat);
    longint unsigned m = (64'd1 << W) - 1;
    int s = int'(b % (64'd1 << SHW));
    int r = s % W;
    res = 0; rem = 0; c = 0; dz = 0; lat = 1;
    case (op)
      4'h0: begin res = (a + b) & m; c = ((a + b) >> W) != 0; end
      4'h1: begin res = (a + (m + 1) - b) & m; c = (a < b); end
      4'h2: begin res = (a * b) & m; c = ((a * b) >> W) != 0; lat = W + 1; end
      4'h3: begin
        if (b == 0) begin res = m; rem = a; dz = 1; end
        else begin res = a / b; rem = a % b; lat = W + 1; end
      end
      4'h4: res = (s >= W) ? 0 : (a << s) & m;
      4'h5: res = (s >= W) ? 0 : (a >> s);
      4'h6: res = ((a << r) | (a >> (W - r))) & m;
      4'h7: res = ((a >> r) | (a << (W - r))) & m;
      4'h8: res = a & b;
      4'h9: res = a | b;
      4'hA: res = a ^ b;
      4'hB: res = ~(a | b) & m;
      4'hC: res = ~(a & b) & m;
      4'hD: res = ~(a ^ b) & m;
      4'hE: res = (a > b) ? 1 : 0;
      4'hF: res = (a == b) ? 1 : 0;
    endcase
  endfunction

  task automatic check_result(input string tag);
    chk({tag, ".out"},   alu_out,   e_res);
    chk({tag, ".rem"},   alu_rem,   e_rem);
    chk({tag, ".carry"}, carry_out, e_c);
    chk({tag, ".zero"},  zero_flag, (e_res == 0));
    chk({tag, ".dz"},    div_zero,  e_dz);
    chk({tag, ".vld"},   out_valid, 1);
    chk({tag, ".rdy"},   in_ready,  0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".out"},   alu_out,   0);
    chk({tag, ".rem"},   alu_rem,   0);
    chk({tag, ".carry"}, carry_out, 0);
    chk({tag, ".zero"},  zero_flag, 0);
    chk({tag, ".dz"},    div_zero,  0);
    chk({tag, ".vld"},   out_valid, 0);
    chk({tag, ".rdy"},   in_ready,  1);
  endtask

  // Drive one op at the falling edge; after the accept edge scramble the inputs
  // and keep in_valid high, which the block must ignore while not idle.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("issue.rdy", in_ready, 1);
    in_valid  = 1'b1;
    alu_sel   = op;
    alu_in_a  = a;
    alu_in_b  = b;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    alu_sel  = 4'($urandom);
    alu_in_a = W'($urandom);
    alu_in_b = W'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    int cyc = 0;
    model(op, a, b, e_res, e_rem, e_c, e_dz, e_lat);
    issue(op, a, b);
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".lat"}, cyc + 1, e_lat);
    check_result(tag);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      alu_sel  = 4'($urandom);
      alu_in_a = W'($urandom);
      alu_in_b = W'($urandom);
      @(posedge clk);
      #1;
      check_result({tag, ".stall"});
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, ".hs_vld"}, out_valid, 0);
    chk({tag, ".hs_rdy"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_sel   = 4'h0;
    alu_in_a  = '0;
    alu_in_b  = '0;
    #12;
    check_cleared("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add3_4", 4'h0, 8'h03, 8'h04, 0);

    // Reset while idle holding a result
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("rst_idle");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset three iterations into a divide
    issue(4'h3, 8'h64, 8'h07);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_div");
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add3_4b", 4'h0, 8'h03, 8'h04, 0);

    run_op("add_c",  4'h0, 8'hF0, 8'h20, 0);
    run_op("sub_b",  4'h1, 8'h05, 8'h07, 1);
    run_op("eq",     4'hF, 8'h5A, 8'h5A, 0);
    run_op("mul_ff", 4'h2, 8'h0F, 8'h11, 0);
    run_op("mul_ov", 4'h2, 8'h10, 8'h10, 0);
    run_op("div",    4'h3, 8'h64, 8'h07, 0);
    run_op("div0",   4'h3, 8'h2A, 8'h00, 2);
    run_op("rol",    4'h6, 8'h81, 8'h01, 0);
    run_op("ror",    4'h7, 8'h01, 8'h03, 0);
    run_op("shl9",   4'h4, 8'h81, 8'h09, 0);
    run_op("mul_bp", 4'h2, 8'h37, 8'h0B, 5);
    run_op("gt",     4'hE, 8'h80, 8'h7F, 0);

    for (int k = 0; k < 150; k++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = a;
      run_op("rnd", op, a, b, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
